cr_ram_rd_arbiter: RTL and testbench

//  Shares one fixed-latency RAM read port between two address-stream requesters using round-robin arbitration.

---
 rtl/cr_ram_rd_arbiter.sv | 170 +++++++++++++++++
 tb/tb_cr_ram_rd_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cr_ram_rd_arbiter.sv
// Round-robin arbiter sharing one fixed-latency RAM read port between two requesters.
// Each requester has a credit counter and an FWFT response FIFO for routing read data back.

module cr_ram_rd_fifo #(
   parameter int DW    = 16,
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_wr,
   input  logic [DW-1:0] i_wdat,
   input  logic          i_rd,
   output logic [DW-1:0] o_rdat,
   output logic          o_empty,
   output logic          o_full
);
   localparam int PW = $clog2(DEPTH);

   logic [DW-1:0] r_mem [DEPTH];
   logic [PW:0]   r_wptr;
   logic [PW:0]   r_rptr;
   logic          w_do_wr;
   logic          w_do_rd;

   assign o_empty = (r_wptr == r_rptr);
   assign o_full  = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
   assign w_do_wr = i_wr & ~o_full;
   assign w_do_rd = i_rd & ~o_empty;
   // Head entry is shown directly (first-word fall-through); zero when empty.
   assign o_rdat  = o_empty ? '0 : r_mem[r_rptr[PW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_do_wr) r_wptr <= r_wptr + (PW+1)'(1);
         if (w_do_rd) r_rptr <= r_rptr + (PW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_wr) r_mem[r_wptr[PW-1:0]] <= i_wdat;
   end
endmodule

module cr_ram_rd_arbiter #(
   parameter int AW         = 8,
   parameter int DW         = 16,
   parameter int RD_LATENCY = 2,
   parameter int FIFO_DEPTH = 4,
   localparam int CRD_W     = $clog2(FIFO_DEPTH+1)
) (
   input  logic             clk,
   input  logic             reset_p,
   input  logic [AW-1:0]    req0_tdata,
   input  logic             req0_tvalid,
   output logic             req0_tready,
   input  logic [AW-1:0]    req1_tdata,
   input  logic             req1_tvalid,
   output logic             req1_tready,
   output logic [AW-1:0]    ram_addr,
   output logic             ram_read,
   input  logic [DW-1:0]    ram_data,
   input  logic             ram_valid,
   output logic [DW-1:0]    rsp0_tdata,
   output logic             rsp0_tvalid,
   input  logic             rsp0_tready,
   output logic [DW-1:0]    rsp1_tdata,
   output logic             rsp1_tvalid,
   input  logic             rsp1_tready,
   output logic [CRD_W-1:0] crd0_cnt,
   output logic [CRD_W-1:0] crd1_cnt,
   output logic             err
);
   localparam logic [CRD_W-1:0] CRD_MAX = CRD_W'(FIFO_DEPTH);

   logic [CRD_W-1:0]      r_crd0;
   logic [CRD_W-1:0]      r_crd1;
   logic                  r_rr_last;
   logic                  r_err;
   logic [RD_LATENCY-1:0] r_tag_vld;
   logic [RD_LATENCY-1:0] r_tag_id;

   logic w_elig0, w_elig1, w_grant0, w_grant1;
   logic w_pop0, w_pop1, w_wr0, w_wr1;
   logic w_full0, w_full1, w_empty0, w_empty1;
   logic w_tag_vld, w_tag_id, w_err_evt;

   // Grants are held off during reset so every non-credit output reads zero.
   assign w_elig0  = ~reset_p & req0_tvalid & (r_crd0 != '0);
   assign w_elig1  = ~reset_p & req1_tvalid & (r_crd1 != '0);
   assign w_grant0 = w_elig0 & (~w_elig1 | r_rr_last);
   assign w_grant1 = w_elig1 & (~w_elig0 | ~r_rr_last);

   assign req0_tready = w_grant0;
   assign req1_tready = w_grant1;
   assign ram_read    = w_grant0 | w_grant1;
   assign ram_addr    = w_grant0 ? req0_tdata : (w_grant1 ? req1_tdata : '0);

   assign w_tag_vld = r_tag_vld[RD_LATENCY-1];
   assign w_tag_id  = r_tag_id[RD_LATENCY-1];
   assign w_wr0     = ram_valid & w_tag_vld & ~w_tag_id;
   assign w_wr1     = ram_valid & w_tag_vld &  w_tag_id;

   assign rsp0_tvalid = ~w_empty0;
   assign rsp1_tvalid = ~w_empty1;
   assign w_pop0      = rsp0_tvalid & rsp0_tready;
   assign w_pop1      = rsp1_tvalid & rsp1_tready;

   assign crd0_cnt = r_crd0;
   assign crd1_cnt = r_crd1;
   assign err      = r_err;

   assign w_err_evt = (ram_valid ^ w_tag_vld)
                    | (w_wr0 & w_full0) | (w_wr1 & w_full1)
                    | (w_pop0 & ~w_grant0 & (r_crd0 == CRD_MAX))
                    | (w_pop1 & ~w_grant1 & (r_crd1 == CRD_MAX));

   cr_ram_rd_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_fifo0 (
      .clk    (clk),
      .rst    (reset_p),
      .i_wr   (w_wr0),
      .i_wdat (ram_data),
      .i_rd   (w_pop0),
      .o_rdat (rsp0_tdata),
      .o_empty(w_empty0),
      .o_full (w_full0)
   );

   cr_ram_rd_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_fifo1 (
      .clk    (clk),
      .rst    (reset_p),
      .i_wr   (w_wr1),
      .i_wdat (ram_data),
      .i_rd   (w_pop1),
      .o_rdat (rsp1_tdata),
      .o_empty(w_empty1),
      .o_full (w_full1)
   );

   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         r_crd0    <= CRD_MAX;
         r_crd1    <= CRD_MAX;
         r_rr_last <= 1'b1;
         r_err     <= 1'b0;
         r_tag_vld <= '0;
         r_tag_id  <= '0;
      end else begin
         r_tag_vld[0] <= ram_read;
         r_tag_id[0]  <= w_grant1;
         for (int i = 1; i < RD_LATENCY; i++) begin
            r_tag_vld[i] <= r_tag_vld[i-1];
            r_tag_id[i]  <= r_tag_id[i-1];
         end

         if (w_grant0)      r_rr_last <= 1'b0;
         else if (w_grant1) r_rr_last <= 1'b1;

         // Saturate at FIFO_DEPTH; an over-return is flagged through err instead.
         if (w_grant0 & ~w_pop0)                              r_crd0 <= r_crd0 - CRD_W'(1);
         else if (w_pop0 & ~w_grant0 & (r_crd0 != CRD_MAX))   r_crd0 <= r_crd0 + CRD_W'(1);
         if (w_grant1 & ~w_pop1)                              r_crd1 <= r_crd1 - CRD_W'(1);
         else if (w_pop1 & ~w_grant1 & (r_crd1 != CRD_MAX))   r_crd1 <= r_crd1 + CRD_W'(1);

         if (w_err_evt) r_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_cr_ram_rd_arbiter.sv
// Bench for cr_ram_rd_arbiter: behavioural RAM (data = 16'hA500|addr), response scoreboard,
// and one task per scenario.

module tb_cr_ram_rd_arbiter;
   localparam int AW = 8;
   localparam int DW = 16;
   localparam int RL = 2;
   localparam int FD = 4;
   localparam int CW = $clog2(FD+1);

   logic          clk = 1'b0;
   logic          reset_p = 1'b1;
   logic [AW-1:0] req0_tdata = '0, req1_tdata = '0;
   logic          req0_tvalid = 1'b0, req1_tvalid = 1'b0;
   logic          req0_tready, req1_tready;
   logic [AW-1:0] ram_addr;
   logic          ram_read;
   logic [DW-1:0] ram_data;
   logic          ram_valid;
   logic [DW-1:0] rsp0_tdata, rsp1_tdata;
   logic          rsp0_tvalid, rsp1_tvalid;
   logic          rsp0_tready = 1'b0, rsp1_tready = 1'b0;
   logic [CW-1:0] crd0_cnt, crd1_cnt;
   logic          err;

   int tests = 0;
   int fails = 0;
   int g0_cnt, g1_cnt, p0_cnt, p1_cnt;
   logic [DW-1:0] q0[$];
   logic [DW-1:0] q1[$];
   bit   chk_err = 1'b1;
   bit   ram_en = 1'b1;
   logic inj = 1'b0;

   logic [RL-1:0] rm_v;
   logic [AW-1:0] rm_a0, rm_a1;

   always #5 clk = ~clk;

   cr_ram_rd_arbiter #(.AW(AW), .DW(DW), .RD_LATENCY(RL), .FIFO_DEPTH(FD)) dut (
      .clk(clk), .reset_p(reset_p),
      .req0_tdata(req0_tdata), .req0_tvalid(req0_tvalid), .req0_tready(req0_tready),
      .req1_tdata(req1_tdata), .req1_tvalid(req1_tvalid), .req1_tready(req1_tready),
      .ram_addr(ram_addr), .ram_read(ram_read), .ram_data(ram_data), .ram_valid(ram_valid),
      .rsp0_tdata(rsp0_tdata), .rsp0_tvalid(rsp0_tvalid), .rsp0_tready(rsp0_tready),
      .rsp1_tdata(rsp1_tdata), .rsp1_tvalid(rsp1_tvalid), .rsp1_tready(rsp1_tready),
      .crd0_cnt(crd0_cnt), .crd1_cnt(crd1_cnt), .err(err)
   );

   // Two-cycle RAM read model; ram_en=0 swallows reads, inj forces a stray ram_valid.
   always @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         rm_v  <= '0;
         rm_a0 <= '0;
         rm_a1 <= '0;
      end else begin
         rm_v  <= {rm_v[0], ram_read & ram_en};
         rm_a0 <= ram_addr;
         rm_a1 <= rm_a0;
      end
   end
   assign ram_valid = rm_v[1] | inj;
   assign ram_data  = 16'hA500 | {8'h00, rm_a1};

   // One clock cycle: sample at negedge+1, score grants/pops, advance to next negedge.
   task automatic step();
      logic [DW-1:0] e;
      logic [AW-1:0] ea;
      #1;
      tests++;
      if ((ram_read !== (req0_tready | req1_tready)) || (req0_tready & req1_tready) ||
          (req0_tready & ~req0_tvalid) || (req1_tready & ~req1_tvalid)) begin
         fails++;
         $display("FAIL grant_onehot: got rd=%b g0=%b g1=%b v0=%b v1=%b", ram_read, req0_tready, req1_tready, req0_tvalid, req1_tvalid);
      end
      ea = req0_tready ? req0_tdata : (req1_tready ? req1_tdata : 8'h00);
      tests++;
      if (ram_addr !== ea) begin
         fails++;
         $display("FAIL ram_addr: got %h want %h", ram_addr, ea);
      end
      if (req0_tready === 1'b1) begin q0.push_back(16'hA500 | {8'h00, req0_tdata}); g0_cnt++; end
      if (req1_tready === 1'b1) begin q1.push_back(16'hA500 | {8'h00, req1_tdata}); g1_cnt++; end
      if (rsp0_tvalid === 1'b1 && rsp0_tready) begin
         tests++;
         if (q0.size() == 0) begin
            fails++;
            $display("FAIL rsp0_unexpected: got %h want none", rsp0_tdata);
         end else begin
            e = q0.pop_front();
            if (rsp0_tdata !== e) begin
               fails++;
               $display("FAIL rsp0_data: got %h want %h", rsp0_tdata, e);
            end
         end
         p0_cnt++;
      end
      if (rsp1_tvalid === 1'b1 && rsp1_tready) begin
         tests++;
         if (q1.size() == 0) begin
            fails++;
            $display("FAIL rsp1_unexpected: got %h want none", rsp1_tdata);
         end else begin
            e = q1.pop_front();
            if (rsp1_tdata !== e) begin
               fails++;
               $display("FAIL rsp1_data: got %h want %h", rsp1_tdata, e);
            end
         end
         p1_cnt++;
      end
      if (chk_err) begin
         tests++;
         if (err !== 1'b0) begin
            fails++;
            $display("FAIL err_clear: got %b want 0", err);
         end
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset_p = 1'b1;
      req0_tvalid = 1'b0; req1_tvalid = 1'b0;
      rsp0_tready = 1'b0; rsp1_tready = 1'b0;
      inj = 1'b0;
      @(negedge clk);
      @(negedge clk);
      q0.delete(); q1.delete();
      g0_cnt = 0; g1_cnt = 0; p0_cnt = 0; p1_cnt = 0;
      reset_p = 1'b0;
   endtask

   task automatic test_reset();
      reset_p = 1'b1;
      req0_tvalid = 1'b1; req1_tvalid = 1'b1; req0_tdata = 8'h33; req1_tdata = 8'h44;
      rsp0_tready = 1'b1; rsp1_tready = 1'b1;
      @(negedge clk);
      #1;
      tests++;
      if ({req0_tready, req1_tready, ram_read, rsp0_tvalid, rsp1_tvalid, err} !== 6'b0 || ram_addr !== 8'h00) begin
         fails++;
         $display("FAIL reset_outputs: got g=%b%b rd=%b addr=%h v=%b%b err=%b want all 0", req0_tready, req1_tready, ram_read, ram_addr, rsp0_tvalid, rsp1_tvalid, err);
      end
      tests++;
      if (crd0_cnt !== 3'd4 || crd1_cnt !== 3'd4) begin
         fails++;
         $display("FAIL reset_crd: got %0d/%0d want 4/4", crd0_cnt, crd1_cnt);
      end
      do_reset();
      #1;
      tests++;
      if (crd0_cnt !== 3'd4 || crd1_cnt !== 3'd4 || err !== 1'b0 || ram_read !== 1'b0 || rsp0_tvalid !== 1'b0 || rsp1_tvalid !== 1'b0) begin
         fails++;
         $display("FAIL post_reset: got crd=%0d/%0d err=%b rd=%b v=%b%b want 4/4 0 0 00", crd0_cnt, crd1_cnt, err, ram_read, rsp0_tvalid, rsp1_tvalid);
      end
      @(negedge clk);
   endtask

   task automatic test_single();
      logic [CW-1:0] ec;
      req0_tdata = 8'h10; req0_tvalid = 1'b1; rsp0_tready = 1'b1;
      #1;
      tests++;
      if (req0_tready !== 1'b1 || ram_read !== 1'b1 || ram_addr !== 8'h10) begin
         fails++;
         $display("FAIL single_grant: got g0=%b rd=%b addr=%h want 1 1 10", req0_tready, ram_read, ram_addr);
      end
      step();
      req0_tvalid = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         ec = (i == 4) ? 3'd4 : 3'd3;
         tests++;
         if (crd0_cnt !== ec || rsp0_tvalid !== (i == 3)) begin
            fails++;
            $display("FAIL single_T+%0d: got crd0=%0d v0=%b want %0d %b", i, crd0_cnt, rsp0_tvalid, ec, (i == 3));
         end
         if (i == 3) begin
            tests++;
            if (rsp0_tdata !== 16'hA510) begin
               fails++;
               $display("FAIL single_data: got %h want a510", rsp0_tdata);
            end
         end
         step();
      end
   endtask

   task automatic test_round_robin();
      do_reset();
      req0_tvalid = 1'b1; req1_tvalid = 1'b1; rsp0_tready = 1'b1; rsp1_tready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         req0_tdata = 8'h30 + 8'(i);
         req1_tdata = 8'h40 + 8'(i);
         #1;
         tests++;
         if (req0_tready !== (i % 2 == 0) || req1_tready !== (i % 2 == 1)) begin
            fails++;
            $display("FAIL rr_cycle%0d: got g0=%b g1=%b want %b %b", i, req0_tready, req1_tready, (i % 2 == 0), (i % 2 == 1));
         end
         step();
      end
      req0_tvalid = 1'b0; req1_tvalid = 1'b0;
      repeat (6) step();
      tests++;
      if (q0.size() != 0 || q1.size() != 0 || crd0_cnt !== 3'd4 || crd1_cnt !== 3'd4) begin
         fails++;
         $display("FAIL rr_drain: got q=%0d/%0d crd=%0d/%0d want 0/0 4/4", q0.size(), q1.size(), crd0_cnt, crd1_cnt);
      end
   endtask

   task automatic test_credit_stall();
      int  idx;
      logic g;
      do_reset();
      idx = 0;
      rsp0_tready = 1'b0; rsp1_tready = 1'b1;
      req0_tvalid = 1'b1; req1_tvalid = 1'b1;
      for (int c = 0; c < 12; c++) begin
         req0_tdata = 8'h20 + 8'(idx);
         req1_tdata = 8'h80 + 8'(c);
         #1;
         g = req0_tready;
         if (c >= 7) begin
            tests++;
            if (req1_tready !== 1'b1) begin
               fails++;
               $display("FAIL stall_req1_c%0d: got %b want 1", c, req1_tready);
            end
         end
         step();
         if (g) idx++;
      end
      req0_tdata = 8'h20 + 8'(idx);
      #1;
      tests++;
      if (g0_cnt != 4 || crd0_cnt !== 3'd0 || req0_tready !== 1'b0) begin
         fails++;
         $display("FAIL stall_full: got g0=%0d crd0=%0d rdy0=%b want 4 0 0", g0_cnt, crd0_cnt, req0_tready);
      end
      rsp0_tready = 1'b1; req1_tvalid = 1'b0;
      for (int c = 0; c < 16; c++) begin
         req0_tdata  = 8'h20 + 8'(idx);
         req0_tvalid = (idx < 6);
         #1;
         g = req0_tready;
         step();
         if (g) idx++;
      end
      tests++;
      if (g0_cnt != 6 || p0_cnt != 6 || q0.size() != 0 || crd0_cnt !== 3'd4) begin
         fails++;
         $display("FAIL stall_release: got g0=%0d p0=%0d q0=%0d crd0=%0d want 6 6 0 4", g0_cnt, p0_cnt, q0.size(), crd0_cnt);
      end
   endtask

   task automatic test_grant_pop_same();
      do_reset();
      rsp0_tready = 1'b0;
      req0_tvalid = 1'b1;
      req0_tdata = 8'h50; step();
      req0_tdata = 8'h51; step();
      req0_tvalid = 1'b0;
      repeat (4) step();
      tests++;
      if (crd0_cnt !== 3'd2 || rsp0_tvalid !== 1'b1) begin
         fails++;
         $display("FAIL gp_setup: got crd0=%0d v0=%b want 2 1", crd0_cnt, rsp0_tvalid);
      end
      req0_tvalid = 1'b1; req0_tdata = 8'h52; rsp0_tready = 1'b1;
      #1;
      tests++;
      if (req0_tready !== 1'b1) begin
         fails++;
         $display("FAIL gp_grant: got %b want 1", req0_tready);
      end
      step();
      req0_tvalid = 1'b0; rsp0_tready = 1'b0;
      tests++;
      if (crd0_cnt !== 3'd2) begin
         fails++;
         $display("FAIL gp_crd: got %0d want 2", crd0_cnt);
      end
      rsp0_tready = 1'b1;
      repeat (6) step();
      tests++;
      if (crd0_cnt !== 3'd4 || q0.size() != 0 || p0_cnt != 3) begin
         fails++;
         $display("FAIL gp_drain: got crd0=%0d q0=%0d p0=%0d want 4 0 3", crd0_cnt, q0.size(), p0_cnt);
      end
   endtask

   task automatic test_err();
      do_reset();
      chk_err = 1'b0;
      repeat (2) step();
      inj = 1'b1;
      step();
      inj = 1'b0;
      tests++;
      if (err !== 1'b1) begin
         fails++;
         $display("FAIL err_stray_valid: got %b want 1", err);
      end
      repeat (3) step();
      tests++;
      if (err !== 1'b1) begin
         fails++;
         $display("FAIL err_sticky: got %b want 1", err);
      end
      do_reset();
      tests++;
      if (err !== 1'b0) begin
         fails++;
         $display("FAIL err_reset: got %b want 0", err);
      end
      ram_en = 1'b0;
      req1_tvalid = 1'b1; req1_tdata = 8'h77;
      step();
      req1_tvalid = 1'b0;
      repeat (3) step();
      tests++;
      if (err !== 1'b1) begin
         fails++;
         $display("FAIL err_missing_valid: got %b want 1", err);
      end
      ram_en = 1'b1;
      do_reset();
      tests++;
      if (err !== 1'b0 || crd1_cnt !== 3'd4) begin
         fails++;
         $display("FAIL err_reset2: got err=%b crd1=%0d want 0 4", err, crd1_cnt);
      end
      chk_err = 1'b1;
      repeat (2) step();
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_credit_stall();
      test_grant_pop_same();
      test_err();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish want finish by 200000");
      $fatal(1);
   end
endmodule
